fft_frame_sequencer: RTL and testbench

Frame-level scheduler for the in-place ping-pong FFT core. Accepts a valid/ready sample stream and drives the core's load port with N=2**N_2 samples. It then pulses start, waits for done with a watchdog, and bursts the N results out as a valid/last stream. Finally it clears the core for the next frame. Sits between the sample source/sink and the core; it owns the core's start, reset, load and rd_adr pins.

---
 rtl/fft_frame_sequencer_if.sv | 40 ++++
 rtl/fft_frame_sequencer.sv | 166 ++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_sequencer_if.sv
// Bundle of the sample stream, FFT core load/control pins, result stream and status
// that connect the frame sequencer to its environment.
interface fft_frame_sequencer_if #(
  parameter int width = 16,
  parameter int N_2   = 5
);
  // in_valid/in_ready: a beat transfers on any clock edge where both are high; the
  // source holds in_data while in_valid is high and in_ready is low. out_valid has
  // no backpressure and every result beat is presented exactly once.
  logic             go;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_data;
  logic             fft_load;
  logic [N_2-1:0]   fft_rd_adr;
  logic [width-1:0] fft_rd;
  logic             fft_start;
  logic             fft_reset;
  logic             fft_done;
  logic [width-1:0] fft_wd;
  logic             out_valid;
  logic [width-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             timeout_err;
  logic [15:0]      frame_cnt;

  modport slave (
    input  go, abort, in_valid, in_data, fft_done, fft_wd,
    output in_ready, fft_load, fft_rd_adr, fft_rd, fft_start, fft_reset,
           out_valid, out_data, out_last, busy, timeout_err, frame_cnt
  );

  modport master (
    output go, abort, in_valid, in_data, fft_done, fft_wd,
    input  in_ready, fft_load, fft_rd_adr, fft_rd, fft_start, fft_reset,
           out_valid, out_data, out_last, busy, timeout_err, frame_cnt
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame scheduler for the ping-pong FFT core: loads N samples, starts the core,
// watches for done, streams the N results out and clears the core between frames.
module fft_frame_sequencer #(
  parameter int width   = 16,
  parameter int N_2     = 5,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fft_frame_sequencer_if.slave  bus,
  output logic [2:0]            state_o
);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam int DR_W = $clog2(RD_LAT + 1) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_CLEAR  = 3'd6;

  logic [2:0]        state_q,     state_d;
  logic [N_2-1:0]    load_cnt_q,  load_cnt_d;
  logic [N_2-1:0]    beat_cnt_q,  beat_cnt_d;
  logic [WD_W-1:0]   wdog_q,      wdog_d;
  logic [DR_W-1:0]   drain_q,     drain_d;
  logic [RD_LAT-1:0] vld_sr_q,    vld_sr_d;
  logic [RD_LAT-1:0] last_sr_q,   last_sr_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q,  out_last_d;
  logic [width-1:0]  out_data_q,  out_data_d;
  logic              timeout_q,   timeout_d;
  logic [15:0]       frame_q,     frame_d;

  logic accept;
  logic issue;
  logic issue_last;

  // abort blocks acceptance so a beat offered in the abort cycle is not swallowed
  assign accept     = (state_q == S_LOAD) && bus.in_valid && !bus.abort;
  assign issue      = ((state_q == S_RUN) && bus.fft_done) || (state_q == S_UNLOAD);
  assign issue_last = (state_q == S_UNLOAD) && (beat_cnt_q == '1);

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    wdog_d      = wdog_q;
    drain_d     = drain_q;
    timeout_d   = timeout_q;
    frame_d     = frame_q;
    out_data_d  = out_data_q;
    vld_sr_d    = '0;
    last_sr_d   = '0;
    vld_sr_d[0]  = issue;
    last_sr_d[0] = issue_last;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_sr_d[i]  = vld_sr_q[i-1];
      last_sr_d[i] = last_sr_q[i-1];
    end
    // the shift-register tail lines up with the core's read data on fft_wd
    out_valid_d = vld_sr_q[RD_LAT-1];
    out_last_d  = last_sr_q[RD_LAT-1];
    if (vld_sr_q[RD_LAT-1]) out_data_d = bus.fft_wd;

    case (state_q)
      S_CLEAR: state_d = S_IDLE;
      S_IDLE:  if (bus.go) state_d = S_LOAD;
      S_LOAD: begin
        if (accept) begin
          load_cnt_d = load_cnt_q + N_2'(1);
          if (load_cnt_q == '1) state_d = S_START;
        end
      end
      S_START: begin
        wdog_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wdog_d = wdog_q + WD_W'(1);
        if (bus.fft_done) begin
          beat_cnt_d = N_2'(1);
          state_d    = S_UNLOAD;
        end else if (wdog_q == WD_W'(TIMEOUT - 2)) begin
          timeout_d = 1'b1;
          state_d   = S_CLEAR;
        end
      end
      S_UNLOAD: begin
        beat_cnt_d = beat_cnt_q + N_2'(1);
        if (beat_cnt_q == '1) begin
          drain_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DR_W'(1);
        if (drain_q == DR_W'(RD_LAT)) begin
          frame_d = frame_q + 16'd1;
          state_d = S_CLEAR;
        end
      end
      default: state_d = S_CLEAR;
    endcase

    if (bus.abort) begin
      state_d     = S_CLEAR;
      timeout_d   = 1'b0;
      load_cnt_d  = '0;
      beat_cnt_d  = '0;
      wdog_d      = '0;
      drain_d     = '0;
      vld_sr_d    = '0;
      last_sr_d   = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_CLEAR;
      load_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      wdog_q      <= '0;
      drain_q     <= '0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      timeout_q   <= 1'b0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      wdog_q      <= wdog_d;
      drain_q     <= drain_d;
      vld_sr_q    <= vld_sr_d;
      last_sr_q   <= last_sr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      timeout_q   <= timeout_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.in_ready    = (state_q == S_LOAD) && !bus.abort;
  assign bus.fft_load    = accept;
  assign bus.fft_rd_adr  = load_cnt_q;
  assign bus.fft_rd      = bus.in_data;
  assign bus.fft_start   = (state_q == S_START);
  assign bus.fft_reset   = (state_q == S_CLEAR);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.timeout_err = timeout_q;
  assign bus.frame_cnt   = frame_q;
  assign state_o         = state_q;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: random sample frames through a behavioural FFT core
// stand-in, with a frame-level scoreboard of expected result words.
module tb_fft_frame_sequencer;
  localparam int W       = 16;
  localparam int N_2     = 5;
  localparam int N       = 1 << N_2;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 128;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] state_dbg;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_frame_sequencer_if #(.width(W), .N_2(N_2)) sq_if ();

  fft_frame_sequencer #(.width(W), .N_2(N_2), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sq_if),
    .state_o (state_dbg)
  );

  // ---------------- checking ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // result the stand-in core produces for natural-order sample k
  function automatic logic [W-1:0] core_fn(input logic [W-1:0] s, input int k);
    logic [W-1:0] r;
    r = s * W'(3) + W'(k);
    return r;
  endfunction

  // ---------------- FFT core stand-in ----------------
  logic [W-1:0]   core_mem [N];
  logic [W-1:0]   core_res [N];
  logic [N_2-1:0] hist [RD_LAT];
  logic [N_2-1:0] out_idx;
  bit             core_run;
  bit             never_done = 1'b0;
  int             core_cnt;
  int             core_delay;

  initial begin
    logic s_load, s_start, s_reset, s_done;
    logic [N_2-1:0] s_adr;
    logic [W-1:0] s_rd;
    for (int k = 0; k < N; k++) begin core_mem[k] = '0; core_res[k] = '0; end
    for (int i = 0; i < RD_LAT; i++) hist[i] = '0;
    out_idx = '0; core_run = 1'b0; core_cnt = 0; core_delay = 0;
    sq_if.fft_done = 1'b0;
    sq_if.fft_wd   = '0;
    forever begin
      @(negedge clk);
      s_load = sq_if.fft_load;  s_adr = sq_if.fft_rd_adr; s_rd = sq_if.fft_rd;
      s_start = sq_if.fft_start; s_reset = sq_if.fft_reset; s_done = sq_if.fft_done;
      @(posedge clk);
      #1;
      for (int i = RD_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = out_idx;
      if (s_reset) begin
        core_run = 1'b0;
        sq_if.fft_done = 1'b0;
        out_idx = '0;
      end else begin
        if (s_load) core_mem[s_adr] = s_rd;
        if (s_done) out_idx = out_idx + N_2'(1);
        if (s_start) begin
          core_run = 1'b1;
          core_cnt = 0;
          core_delay = $urandom_range(5, 90);
          for (int k = 0; k < N; k++) core_res[k] = core_fn(core_mem[k], k);
        end else if (core_run && !sq_if.fft_done) begin
          core_cnt++;
          if (core_cnt >= core_delay && !never_done) sq_if.fft_done = 1'b1;
        end
      end
      sq_if.fft_wd = core_res[hist[RD_LAT-1]];
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_last_q[$];
  logic [W-1:0] frame_buf[$];
  int  start_cyc = 0, done_rise_cyc = 0, full_cyc = 0, reset_len = 0, to_seen = 0;
  bit  first_pending = 1'b0, prev_done = 1'b0, prev_to = 1'b0, prev_reset = 1'b0;

  initial begin
    logic [W-1:0] e;
    logic         l;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_done = 1'b0; prev_to = 1'b0; prev_reset = 1'b0; reset_len = 0;
      end else begin
        if (sq_if.out_valid) begin
          if (exp_q.size() == 0) check("spurious_out_valid", 1, 0);
          else begin
            e = exp_q.pop_front();
            l = exp_last_q.pop_front();
            check("out_data", sq_if.out_data, e);
            check("out_last", sq_if.out_last, l);
            if (first_pending) begin
              check("first_beat_lat", cyc - done_rise_cyc, RD_LAT + 1);
              first_pending = 1'b0;
            end
          end
        end
        if (sq_if.in_valid && sq_if.in_ready) begin
          check("load_strobe", sq_if.fft_load, 1);
          check("load_adr", sq_if.fft_rd_adr, frame_buf.size());
          check("load_data", sq_if.fft_rd, sq_if.in_data);
          frame_buf.push_back(sq_if.in_data);
          if (frame_buf.size() == N) begin
            for (int k = 0; k < N; k++) begin
              exp_q.push_back(core_fn(frame_buf[k], k));
              exp_last_q.push_back(k == N - 1);
            end
            frame_buf.delete();
            full_cyc = cyc;
          end
        end else if (sq_if.fft_load) check("load_strobe", 1, 0);
        if (sq_if.fft_start) begin
          start_cyc = cyc;
          check("start_lat", cyc - full_cyc, 1);
        end
        if (sq_if.fft_done && !prev_done) begin
          done_rise_cyc = cyc;
          first_pending = 1'b1;
        end
        if (sq_if.timeout_err && !prev_to) begin
          check("timeout_lat", cyc - start_cyc, TIMEOUT);
          to_seen++;
          exp_q.delete(); exp_last_q.delete();
        end
        if (sq_if.fft_reset) reset_len++;
        else if (prev_reset) begin
          check("reset_len", reset_len, 1);
          reset_len = 0;
        end
        if (sq_if.abort) begin
          frame_buf.delete(); exp_q.delete(); exp_last_q.delete();
          first_pending = 1'b0;
        end
        prev_done  = sq_if.fft_done;
        prev_to    = sq_if.timeout_err;
        prev_reset = sq_if.fft_reset;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: continuous, 1: one idle cycle between beats, 2: random gaps
  task automatic send_frame(input int mode, input int abort_at);
    bit acc;
    int budget;
    int g;
    for (int i = 0; i < N; i++) begin
      if (mode == 1 && i > 0) begin
        sq_if.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (mode == 2) begin
        g = $urandom_range(0, 2);
        sq_if.in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      sq_if.in_valid = 1'b1;
      sq_if.in_data  = W'($urandom);
      if (i == abort_at) begin
        sq_if.abort = 1'b1;
        @(posedge clk); #1;
        sq_if.abort = 1'b0;
        sq_if.in_valid = 1'b0;
        return;
      end
      acc = 1'b0;
      budget = 0;
      while (!acc) begin
        @(negedge clk);
        acc = sq_if.in_ready;
        @(posedge clk); #1;
        budget++;
        if (!acc && budget > 2000) begin
          check("load_accept_timeout", 0, 1);
          sq_if.in_valid = 1'b0;
          return;
        end
      end
    end
    sq_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sq_if.busy && n < budget);
    if (sq_if.busy) check("idle_timeout", 0, 1);
  endtask

  // ---------------- main sequence ----------------
  int frames_exp = 0;

  initial begin
    int n;
    sq_if.go = 1'b0; sq_if.abort = 1'b0; sq_if.in_valid = 1'b0; sq_if.in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fft_reset", sq_if.fft_reset, 1);
    check("rst_busy", sq_if.busy, 1);
    check("rst_in_ready", sq_if.in_ready, 0);
    check("rst_out_valid", sq_if.out_valid, 0);
    check("rst_out_last", sq_if.out_last, 0);
    check("rst_out_data", sq_if.out_data, 0);
    check("rst_timeout", sq_if.timeout_err, 0);
    check("rst_frame_cnt", sq_if.frame_cnt, 0);
    check("rst_start", sq_if.fft_start, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("clear_after_rst", sq_if.fft_reset, 1);
    @(negedge clk);
    check("idle_busy", sq_if.busy, 0);
    check("idle_fft_reset", sq_if.fft_reset, 0);

    // three frames: continuous, toggling valid, random gaps
    for (int m = 0; m < 3; m++) begin
      @(posedge clk); #1;
      sq_if.go = 1'b1;
      send_frame(m, -1);
      sq_if.go = 1'b0;
      wait_idle(1000);
      frames_exp++;
      check("frame_cnt", sq_if.frame_cnt, frames_exp);
      check("exp_drained", exp_q.size(), 0);
    end

    // watchdog: core never raises done
    never_done = 1'b1;
    @(posedge clk); #1;
    sq_if.go = 1'b1;
    send_frame(0, -1);
    sq_if.go = 1'b0;
    wait_idle(1000);
    never_done = 1'b0;
    check("timeout_err_set", sq_if.timeout_err, 1);
    check("timeout_seen", to_seen, 1);
    check("timeout_frame_cnt", sq_if.frame_cnt, frames_exp);
    @(posedge clk); #1;
    sq_if.abort = 1'b1;
    @(posedge clk); #1;
    sq_if.abort = 1'b0;
    @(negedge clk);
    check("abort_clears_timeout", sq_if.timeout_err, 0);
    check("abort_goes_clear", sq_if.fft_reset, 1);
    wait_idle(100);

    // abort on the 17th load beat, then a full frame from index 0
    @(posedge clk); #1;
    sq_if.go = 1'b1;
    send_frame(0, 16);
    @(negedge clk);
    check("abort_load_in_ready", sq_if.in_ready, 0);
    check("abort_load_clear", sq_if.fft_reset, 1);
    @(posedge clk); #1;
    send_frame(2, -1);
    sq_if.go = 1'b0;
    wait_idle(1000);
    frames_exp++;
    check("frame_cnt_after_load_abort", sq_if.frame_cnt, frames_exp);

    // abort while unload beat 10 is issued
    @(posedge clk); #1;
    sq_if.go = 1'b1;
    send_frame(0, -1);
    sq_if.go = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!sq_if.fft_done && n < 300);
    check("done_seen", sq_if.fft_done, 1);
    repeat (10) begin @(posedge clk); #1; end
    sq_if.abort = 1'b1;
    @(posedge clk); #1;
    sq_if.abort = 1'b0;
    @(negedge clk);
    check("unload_abort_valid", sq_if.out_valid, 0);
    check("unload_abort_last", sq_if.out_last, 0);
    wait_idle(200);
    repeat (4) @(negedge clk);
    check("unload_abort_frame_cnt", sq_if.frame_cnt, frames_exp);

    // back-to-back frames with go held high
    @(posedge clk); #1;
    sq_if.go = 1'b1;
    send_frame(2, -1);
    send_frame(0, -1);
    sq_if.go = 1'b0;
    wait_idle(1000);
    frames_exp += 2;
    check("b2b_frame_cnt", sq_if.frame_cnt, frames_exp);
    check("b2b_exp_drained", exp_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
